// File: rtl/msk_unmask_pkg.sv
// Shared types and helpers for the share-recombination block.
package msk_unmask_pkg;

  // Sequencer phases: wait for a sharing, fold shares, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Share-index counter width; at least one bit so d=1 still has a counter.
  function automatic int cnt_w(input int d);
    return (d <= 1) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/msk_unmask_seq_if.sv
// Handshake bundle between a masked producer and the recombination block.
interface msk_unmask_seq_if #(
  parameter int d     = 2,
  parameter int count = 1
);
  logic                 in_valid;
  logic                 in_ready;
  logic [count*d-1:0]   in_sh;
  logic                 out_valid;
  logic                 out_ready;
  logic [count-1:0]     out;

  // Producer/consumer side of the block.
  modport master (
    output in_valid, in_sh, out_ready,
    input  in_ready, out_valid, out
  );

  // The recombination block itself.
  modport slave (
    input  in_valid, in_sh, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/msk_unmask_lane.sv
// One bit lane: holds the registered shares of a single sharing and
// folds them into a 1-bit accumulator, one share per fold cycle.
module msk_unmask_lane
  import msk_unmask_pkg::*;
#(
  parameter int d     = 2,
  parameter int CNT_W = cnt_w(d)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             fold,
  input  logic             clear,
  input  logic [CNT_W-1:0] cnt,
  input  logic [d-1:0]     sh_in,
  output logic             acc
);

  logic [d-1:0] sh_reg;
  logic         acc_reg;
  logic [d-1:0] one_hot;

  // Decode the share index being folded this cycle into a slot mask.
  always_comb begin
    one_hot = '0;
    for (int j = 0; j < d; j++) begin
      if (cnt == CNT_W'(j)) one_hot[j] = 1'b1;
    end
  end

  // Capture shares, fold one slot per cycle (wiping it), clear after hand-off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_reg  <= '0;
      acc_reg <= 1'b0;
    end else if (load) begin
      sh_reg  <= sh_in;
      acc_reg <= 1'b0;
    end else if (fold) begin
      acc_reg <= acc_reg ^ (|(sh_reg & one_hot));
      sh_reg  <= sh_reg & ~one_hot;
    end else if (clear) begin
      acc_reg <= 1'b0;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/msk_unmask_seq.sv
// Recombines d-share sharings into plain bits. Shares are registered first,
// then folded one share index per cycle across all lanes in parallel.
module msk_unmask_seq
  import msk_unmask_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  msk_unmask_seq_if.slave    bus
);

  localparam int CNT_W = cnt_w(d);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             load, fold, clear;
  logic [count-1:0] acc_vec;

  // State and share-index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and lane control; in_ready/out_valid depend only on state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    fold       = 1'b0;
    clear      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = ACC;
        end
      end
      ACC: begin
        fold = 1'b1;
        if (cnt_reg == CNT_W'(d - 1)) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          clear      = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out       = acc_vec;

  for (genvar gi = 0; gi < count; gi++) begin : gen_lane
    msk_unmask_lane #(
      .d     (d),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .fold  (fold),
      .clear (clear),
      .cnt   (cnt_reg),
      .sh_in (bus.in_sh[gi*d +: d]),
      .acc   (acc_vec[gi])
    );
  end

endmodule
